// File: rtl/prm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : prm_pkg                                                          |
// | Shared types for the PRM edge-sweep initiator: joint/config packing and    |
// | the sweep FSM state encoding.                                              |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package prm_pkg;

    localparam int JOINT_W = 5;
    localparam int NJOINT  = 3;
    localparam int CODE_W  = 15;

    typedef logic [JOINT_W-1:0] joint_t;
    // Packed so that element 0 is J0 = bits [4:0] of the 15-bit code.
    typedef joint_t [NJOINT-1:0] cfg_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_EVAL  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/prm_interp_joint.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : prm_interp_joint                                                 |
// | Combinational single-joint linear interpolation:                           |
// |   s = qa + floor(((qb - qa) * step) / 2**LOG2_STEPS)                       |
// | Ports   : qa     in  joint start value (unsigned)                          |
// |           qb     in  joint end value (unsigned)                            |
// |           step   in  sample index 0..2**LOG2_STEPS                         |
// |           sample out interpolated joint value                              |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module prm_interp_joint
    import prm_pkg::*;
#(
    parameter int LOG2_STEPS = 3
) (
    input  joint_t              qa,
    input  joint_t              qb,
    input  logic [LOG2_STEPS:0] step,
    output joint_t              sample
);

    // Wide enough for the signed difference times the largest step index.
    localparam int PW = JOINT_W + LOG2_STEPS + 4;

    logic signed [PW-1:0] w_qa_ext;
    logic signed [PW-1:0] w_qb_ext;
    logic signed [PW-1:0] w_step_ext;
    logic signed [PW-1:0] w_diff;
    logic signed [PW-1:0] w_prod;
    logic signed [PW-1:0] w_shift;
    logic signed [PW-1:0] w_sum;
    logic                 w_sum_unused;

    assign w_qa_ext   = $signed({{(PW-JOINT_W){1'b0}}, qa});
    assign w_qb_ext   = $signed({{(PW-JOINT_W){1'b0}}, qb});
    assign w_step_ext = $signed({{(PW-LOG2_STEPS-1){1'b0}}, step});
    assign w_diff     = w_qb_ext - w_qa_ext;
    assign w_prod     = w_diff * w_step_ext;
    // Arithmetic shift floors toward -inf, so descending edges round down.
    assign w_shift    = w_prod >>> LOG2_STEPS;
    assign w_sum      = w_qa_ext + w_shift;

    // The sum always lies between qa and qb, so the upper bits are zero.
    assign sample       = w_sum[JOINT_W-1:0];
    assign w_sum_unused = |w_sum[PW-1:JOINT_W];

endmodule
`default_nettype wire

// File: rtl/prm_edge_sweep_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : prm_edge_sweep_seq                                               |
// | Walks 2**LOG2_STEPS+1 interpolated samples of a roadmap edge, drives each  |
// | to the checker bank and reports edge-free or first blocking sample/checker.|
// | Ports   : clk, rst_n (async, active-low)                                   |
// |           req_valid/req_ready/req_qa/req_qb   edge request handshake       |
// |           chk_code out / chk_mask in          checker bank interface       |
// |           rsp_valid/rsp_ready/rsp_free/rsp_step/rsp_chk  result handshake  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module prm_edge_sweep_seq
    import prm_pkg::*;
#(
    parameter int NCHK       = 16,
    parameter int LOG2_STEPS = 3,
    parameter int CHK_LAT    = 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  req_valid,
    output logic                                  req_ready,
    input  logic [CODE_W-1:0]                     req_qa,
    input  logic [CODE_W-1:0]                     req_qb,
    output logic [CODE_W-1:0]                     chk_code,
    input  logic [NCHK-1:0]                       chk_mask,
    output logic                                  rsp_valid,
    input  logic                                  rsp_ready,
    output logic                                  rsp_free,
    output logic [LOG2_STEPS:0]                   rsp_step,
    output logic [((NCHK > 1) ? $clog2(NCHK) : 1)-1:0] rsp_chk
);

    localparam int STEP_W = LOG2_STEPS + 1;
    localparam int CHK_W  = (NCHK > 1) ? $clog2(NCHK) : 1;
    localparam int WAIT_W = (CHK_LAT > 2) ? $clog2(CHK_LAT) : 1;

    localparam logic [STEP_W-1:0] c_LAST_STEP = STEP_W'(1 << LOG2_STEPS);
    // WAIT lasts CHK_LAT-1 cycles; the counter runs 0..CHK_LAT-2.
    localparam logic [WAIT_W-1:0] c_WAIT_LAST = WAIT_W'((CHK_LAT > 1) ? (CHK_LAT - 2) : 0);

    state_t              r_state;
    state_t              w_next_state;
    cfg_t                r_qa;
    cfg_t                r_qb;
    logic [STEP_W-1:0]   r_step;
    logic [WAIT_W-1:0]   r_wait;
    logic [CODE_W-1:0]   r_code;
    logic                r_free;
    logic [STEP_W-1:0]   r_rsp_step;
    logic [CHK_W-1:0]    r_rsp_chk;
    cfg_t                w_sample;
    logic                w_hit;
    logic [CHK_W-1:0]    w_hit_idx;

    // ------------------------------------------------------------------
    // Per-joint interpolators
    // ------------------------------------------------------------------
    generate
        for (genvar k = 0; k < NJOINT; k++) begin : g_joint
            prm_interp_joint #(
                .LOG2_STEPS (LOG2_STEPS)
            ) u_interp (
                .qa     (r_qa[k]),
                .qb     (r_qb[k]),
                .step   (r_step),
                .sample (w_sample[k])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Lowest-index priority encoder over the checker mask
    // ------------------------------------------------------------------
    assign w_hit = |chk_mask;

    always_comb begin
        w_hit_idx = '0;
        for (int i = NCHK - 1; i >= 0; i--) begin
            if (chk_mask[i]) begin
                w_hit_idx = CHK_W'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_next_state = (CHK_LAT > 1) ? ST_WAIT : ST_EVAL;
            end
            ST_WAIT: begin
                if (r_wait == c_WAIT_LAST) begin
                    w_next_state = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (w_hit || (r_step == c_LAST_STEP)) begin
                    w_next_state = ST_RESP;
                end else begin
                    w_next_state = ST_ISSUE;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_qa       <= '0;
            r_qb       <= '0;
            r_step     <= '0;
            r_wait     <= '0;
            r_code     <= '0;
            r_free     <= 1'b0;
            r_rsp_step <= '0;
            r_rsp_chk  <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_qa   <= req_qa;
                        r_qb   <= req_qb;
                        r_step <= '0;
                    end
                end
                ST_ISSUE: begin
                    r_code <= w_sample;
                    r_wait <= '0;
                end
                ST_WAIT: begin
                    r_wait <= r_wait + WAIT_W'(1);
                end
                ST_EVAL: begin
                    if (w_hit) begin
                        r_free     <= 1'b0;
                        r_rsp_step <= r_step;
                        r_rsp_chk  <= w_hit_idx;
                    end else if (r_step == c_LAST_STEP) begin
                        r_free     <= 1'b1;
                        r_rsp_step <= '0;
                        r_rsp_chk  <= '0;
                    end else begin
                        r_step <= r_step + STEP_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign req_ready = (r_state == ST_IDLE);
    assign rsp_valid = (r_state == ST_RESP);
    assign chk_code  = r_code;
    assign rsp_free  = r_free;
    assign rsp_step  = r_rsp_step;
    assign rsp_chk   = r_rsp_chk;

endmodule
`default_nettype wire

// File: tb/tb_prm_edge_sweep_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_prm_edge_sweep_seq                                            |
// | Directed bench for prm_edge_sweep_seq: one instance at CHK_LAT=1 driven by |
// | a combinational checker model, one at CHK_LAT=3 driven by a timed mask.    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_prm_edge_sweep_seq;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // CHK_LAT = 1 instance
    logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_free;
    logic [14:0] req_qa, req_qb, chk_code;
    logic [15:0] mask1;
    logic [3:0]  rsp_step, rsp_chk;
    logic        hit_en;
    logic [14:0] hit_code;

    // CHK_LAT = 3 instance
    logic        req_valid3, req_ready3, rsp_valid3, rsp_ready3, rsp_free3;
    logic [14:0] req_qa3, req_qb3, chk_code3;
    logic [15:0] mask3;
    logic [3:0]  rsp_step3, rsp_chk3;

    // Checker-bank model: checkers 5 and 9 flag one specific code.
    assign mask1 = (hit_en && (chk_code == hit_code)) ? 16'h0220 : 16'h0000;

    prm_edge_sweep_seq #(.NCHK(16), .LOG2_STEPS(3), .CHK_LAT(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_qa    (req_qa),
        .req_qb    (req_qb),
        .chk_code  (chk_code),
        .chk_mask  (mask1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_free  (rsp_free),
        .rsp_step  (rsp_step),
        .rsp_chk   (rsp_chk)
    );

    prm_edge_sweep_seq #(.NCHK(16), .LOG2_STEPS(3), .CHK_LAT(3)) u_dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid3),
        .req_ready (req_ready3),
        .req_qa    (req_qa3),
        .req_qb    (req_qb3),
        .chk_code  (chk_code3),
        .chk_mask  (mask3),
        .rsp_valid (rsp_valid3),
        .rsp_ready (rsp_ready3),
        .rsp_free  (rsp_free3),
        .rsp_step  (rsp_step3),
        .rsp_chk   (rsp_chk3)
    );

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    logic [4:0]  asc_j  [9] = '{5'd0, 5'd3, 5'd7, 5'd11, 5'd15, 5'd19, 5'd23, 5'd27, 5'd31};
    logic [4:0]  desc_j [9] = '{5'd31, 5'd27, 5'd23, 5'd20, 5'd16, 5'd12, 5'd9, 5'd5, 5'd2};
    logic [14:0] asc_codes  [9];
    logic [14:0] desc_codes [9];
    logic [14:0] same_codes [9];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept a request, then follow the full 18-cycle free sweep.
    task automatic sweep_free(input string tag, input logic [14:0] a, input logic [14:0] b,
                              input logic [14:0] exp_code [9]);
        req_qa    = a;
        req_qb    = b;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        for (int n = 1; n <= 18; n++) begin
            step();
            if ((n % 2) == 1) begin
                check($sformatf("%s code j=%0d", tag, (n - 1) / 2), {17'd0, chk_code},
                      {17'd0, exp_code[(n - 1) / 2]});
            end
            check($sformatf("%s rsp_valid cyc=%0d", tag, n), {31'd0, rsp_valid}, {31'd0, (n == 18)});
        end
        check({tag, " rsp_free"}, {31'd0, rsp_free}, 32'd1);
        check({tag, " rsp_step"}, {28'd0, rsp_step}, 32'd0);
        check({tag, " rsp_chk"},  {28'd0, rsp_chk},  32'd0);
        rsp_ready = 1'b1;
        step();
        check({tag, " ack rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        check({tag, " ack req_ready"}, {31'd0, req_ready}, 32'd1);
        rsp_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int j = 0; j < 9; j++) begin
            asc_codes[j]  = {asc_j[j], asc_j[j], asc_j[j]};
            desc_codes[j] = {10'd0, desc_j[j]};
            same_codes[j] = 15'h2A5A;
        end
        req_valid  = 1'b0; req_qa  = '0; req_qb  = '0; rsp_ready  = 1'b0;
        hit_en     = 1'b0; hit_code = '0;
        req_valid3 = 1'b0; req_qa3 = '0; req_qb3 = '0; rsp_ready3 = 1'b0; mask3 = '0;

        // Reset state
        step();
        step();
        check("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset chk_code",  {17'd0, chk_code},  32'd0);
        check("reset rsp_free",  {31'd0, rsp_free},  32'd0);
        check("reset rsp_step",  {28'd0, rsp_step},  32'd0);
        check("reset rsp_chk",   {28'd0, rsp_chk},   32'd0);
        rst_n = 1'b1;
        step();
        check("post-reset req_ready", {31'd0, req_ready}, 32'd1);

        // Free ascending edge
        sweep_free("free", 15'h0000, 15'h7FFF, asc_codes);

        // Hit at j=4 (code 15,15,15), checkers 5 and 9
        hit_code  = {5'd15, 5'd15, 5'd15};
        hit_en    = 1'b1;
        req_qa    = 15'h0000;
        req_qb    = 15'h7FFF;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            step();
            check($sformatf("hit rsp_valid cyc=%0d", n), {31'd0, rsp_valid}, {31'd0, (n == 10)});
        end
        check("hit rsp_free", {31'd0, rsp_free}, 32'd0);
        check("hit rsp_step", {28'd0, rsp_step}, 32'd4);
        check("hit rsp_chk",  {28'd0, rsp_chk},  32'd5);

        // Backpressure: response held, no new codes, no new request taken
        req_valid = 1'b1;
        for (int n = 0; n < 10; n++) begin
            step();
            check("bp rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("bp rsp_step",  {28'd0, rsp_step},  32'd4);
            check("bp rsp_chk",   {28'd0, rsp_chk},   32'd5);
            check("bp req_ready", {31'd0, req_ready}, 32'd0);
            check("bp chk_code",  {17'd0, chk_code},  {17'd0, hit_code});
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        check("bp release rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("bp release req_ready", {31'd0, req_ready}, 32'd1);
        rsp_ready = 1'b0;
        hit_en    = 1'b0;

        // Descending J0 with rsp_ready already high when rsp_valid rises
        rsp_ready = 1'b1;
        sweep_free("desc", {10'd0, 5'd31}, {10'd0, 5'd2}, desc_codes);

        // qa == qb still runs the whole sweep
        sweep_free("same", 15'h2A5A, 15'h2A5A, same_codes);

        // Reset in the middle of a sweep
        req_qa    = 15'h0000;
        req_qb    = 15'h7FFF;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        for (int n = 1; n <= 7; n++) step();
        check("midrst code j=3", {17'd0, chk_code}, {17'd0, asc_codes[3]});
        rst_n = 1'b0;
        #1;
        check("midrst chk_code",  {17'd0, chk_code},  32'd0);
        check("midrst rsp_valid", {31'd0, rsp_valid}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        check("midrst req_ready", {31'd0, req_ready}, 32'd1);
        for (int n = 0; n < 20; n++) begin
            step();
            check("midrst no response", {31'd0, rsp_valid}, 32'd0);
        end
        req_qa    = 15'h7FFF;
        req_qb    = 15'h0000;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        check("restart code j=0", {17'd0, chk_code}, 32'h7FFF);
        step();
        step();
        check("restart code j=1", {17'd0, chk_code}, {17'd0, 5'd27, 5'd27, 5'd27});
        for (int n = 4; n <= 18; n++) begin
            step();
            check($sformatf("restart rsp_valid cyc=%0d", n), {31'd0, rsp_valid}, {31'd0, (n == 18)});
        end
        check("restart rsp_free", {31'd0, rsp_free}, 32'd1);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // CHK_LAT = 3: stray mask in ISSUE/WAIT ignored, hit at j=0 seen in EVAL
        req_qa3    = 15'h0421;
        req_qb3    = 15'h7FFF;
        req_valid3 = 1'b1;
        step();
        req_valid3 = 1'b0;
        mask3      = 16'h0004;
        step();
        check("lat3 code j=0",      {17'd0, chk_code3},  32'h0421);
        check("lat3 rsp_valid c1",  {31'd0, rsp_valid3}, 32'd0);
        step();
        check("lat3 rsp_valid c2",  {31'd0, rsp_valid3}, 32'd0);
        step();
        check("lat3 rsp_valid c3",  {31'd0, rsp_valid3}, 32'd0);
        mask3 = 16'h0080;
        step();
        mask3 = 16'h0000;
        check("lat3 rsp_valid c4",  {31'd0, rsp_valid3}, 32'd1);
        check("lat3 rsp_free",      {31'd0, rsp_free3},  32'd0);
        check("lat3 rsp_step",      {28'd0, rsp_step3},  32'd0);
        check("lat3 rsp_chk",       {28'd0, rsp_chk3},   32'd7);
        rsp_ready3 = 1'b1;
        step();
        check("lat3 ack req_ready", {31'd0, req_ready3}, 32'd1);
        rsp_ready3 = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
